stack_unit: RTL and testbench

- Parametrised hardware stack: successor to the bare 8-bit push/pop pointer.
- Adds integrated LIFO storage, configurable width/depth, full/empty flags, guarded push/pop, simultaneous push+pop (replace-top), and sticky overflow/underflow errors.
- Sits beside the control unit for CALL/RET and PUSH/POP instructions; the datapath reads the top-of-stack.

---
 rtl/stack_unit.sv | 67 ++++++
 tb/tb_stack_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// stack_unit: parametrised LIFO with full/empty flags, replace-top and sticky errors.
// Define STACK_WATERMARK_EN to add the max_ptr high-water-mark output.
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top_data,
    output logic [ADDR_W:0]   pointer,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
`ifdef STACK_WATERMARK_EN
    ,output logic [ADDR_W:0]  max_ptr
`endif
);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CAP  = (ADDR_W+1)'(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   ptr_m1;
    logic [ADDR_W:0]   wr_idx;
    logic [ADDR_W:0]   next_ptr;
    logic              do_push;
    logic              do_pop;
    logic              do_repl;
    logic              ovf_ev;
    logic              unf_ev;
    assign empty  = pointer == '0;
    assign full   = pointer == CAP;
    assign ptr_m1 = pointer - ONE;
    assign top_data = empty ? '0 : mem[ptr_m1[ADDR_W-1:0]];
    // push+pop on a non-empty stack overwrites the top; on an empty stack it degrades to a push
    always_comb begin
        do_repl  = push && pop && !empty;
        do_push  = push && !do_repl && !full;
        do_pop   = pop && !push && !empty;
        ovf_ev   = push && !pop && full;
        unf_ev   = pop && empty;
        wr_idx   = do_repl ? ptr_m1 : pointer;
        next_ptr = do_push ? pointer + ONE : do_pop ? ptr_m1 : pointer;
    end
    always_ff @(posedge clk)
        if (!rst && (do_push || do_repl)) mem[wr_idx[ADDR_W-1:0]] <= push_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            pointer   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pointer   <= next_ptr;
            overflow  <= ovf_ev || (overflow && !err_clr);
            underflow <= unf_ev || (underflow && !err_clr);
        end
    end
`ifdef STACK_WATERMARK_EN
    always_ff @(posedge clk)
        if (rst) max_ptr <= '0;
        else if (next_ptr > max_ptr) max_ptr <= next_ptr;
`endif
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed plan plus random traffic checked against a queue-based LIFO model.
module tb_stack_unit;
    localparam int DW = 8;
    localparam int DEP = 4;
    logic clk = 0, rst = 1, push = 0, pop = 0, err_clr = 0;
    logic [DW-1:0] push_data = 0;
    logic [DW-1:0] top_data;
    logic [2:0] pointer;
    logic empty, full, overflow, underflow;
`ifdef STACK_WATERMARK_EN
    logic [2:0] max_ptr;
`endif
    int checks = 0, errors = 0;

    stack_unit #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
        .err_clr(err_clr), .top_data(top_data), .pointer(pointer), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow)
`ifdef STACK_WATERMARK_EN
        , .max_ptr(max_ptr)
`endif
    );

    always #5 clk = ~clk;

    // reference model: a queue whose back is the top of stack
    logic [DW-1:0] q[$];
    bit m_ovf, m_unf, armed;
    int m_max;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_max = 0; armed = 1;
        end else begin
            if (err_clr) begin m_ovf = 0; m_unf = 0; end
            if (push && pop) begin
                if (q.size() > 0) q[q.size()-1] = push_data;
                else begin q.push_back(push_data); m_unf = 1; end
            end else if (push) begin
                if (q.size() == DEP) m_ovf = 1;
                else q.push_back(push_data);
            end else if (pop) begin
                if (q.size() == 0) m_unf = 1;
                else void'(q.pop_back());
            end
            if (q.size() > m_max) m_max = q.size();
        end
    end

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp("m_ptr", 32'(pointer), 32'(q.size()));
            cmp("m_empty", 32'(empty), 32'(q.size() == 0));
            cmp("m_full", 32'(full), 32'(q.size() == DEP));
            cmp("m_top", 32'(top_data), q.size() ? 32'(q[q.size()-1]) : 32'd0);
            cmp("m_ovf", 32'(overflow), 32'(m_ovf));
            cmp("m_unf", 32'(underflow), 32'(m_unf));
`ifdef STACK_WATERMARK_EN
            cmp("m_max", 32'(max_ptr), 32'(m_max));
`endif
        end
    end

    task automatic op(input logic p, input logic o, input logic [DW-1:0] d,
                      input logic c, input logic r);
        @(negedge clk);
        push = p; pop = o; push_data = d; err_clr = c; rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        op(0, 0, 0, 0, 1);
        op(0, 0, 0, 0, 1);
        cmp("rst_ptr", 32'(pointer), 0);
        cmp("rst_empty", 32'(empty), 1);
        cmp("rst_top", 32'(top_data), 0);
        op(1, 0, 8'h11, 0, 0);
        op(1, 0, 8'h22, 0, 0);
        op(1, 0, 8'h33, 0, 0);
        cmp("p3_ptr", 32'(pointer), 3);
        cmp("p3_top", 32'(top_data), 32'h33);
        cmp("p3_full", 32'(full), 0);
        op(1, 0, 8'h44, 0, 0);
        cmp("p4_ptr", 32'(pointer), 4);
        cmp("p4_full", 32'(full), 1);
        cmp("p4_top", 32'(top_data), 32'h44);
        op(1, 0, 8'h55, 0, 0);
        cmp("ovf_ptr", 32'(pointer), 4);
        cmp("ovf_top", 32'(top_data), 32'h44);
        cmp("ovf_flag", 32'(overflow), 1);
        op(0, 1, 0, 0, 0);
        cmp("pop1_top", 32'(top_data), 32'h33);
        op(0, 1, 0, 0, 0);
        cmp("pop2_top", 32'(top_data), 32'h22);
        op(0, 1, 0, 0, 0);
        cmp("pop3_top", 32'(top_data), 32'h11);
        op(0, 1, 0, 0, 0);
        cmp("pop4_top", 32'(top_data), 0);
        op(0, 1, 0, 0, 0);
        cmp("unf_ptr", 32'(pointer), 0);
        cmp("unf_empty", 32'(empty), 1);
        cmp("unf_flag", 32'(underflow), 1);
        op(0, 0, 0, 1, 0);
        cmp("clr_ovf", 32'(overflow), 0);
        cmp("clr_unf", 32'(underflow), 0);
        op(1, 0, 8'h11, 0, 0);
        op(1, 0, 8'h22, 0, 0);
        op(1, 1, 8'hAA, 0, 0);
        cmp("repl_ptr", 32'(pointer), 2);
        cmp("repl_top", 32'(top_data), 32'hAA);
        cmp("repl_err", 32'({overflow, underflow}), 0);
        op(0, 1, 0, 0, 0);
        op(0, 1, 0, 0, 0);
        op(1, 1, 8'h5A, 0, 0);
        cmp("pe_ptr", 32'(pointer), 1);
        cmp("pe_top", 32'(top_data), 32'h5A);
        cmp("pe_unf", 32'(underflow), 1);
        op(0, 1, 0, 0, 0);
        op(0, 0, 0, 1, 0);
        cmp("clr2_unf", 32'(underflow), 0);
        op(0, 1, 0, 1, 0);
        cmp("setwin_unf", 32'(underflow), 1);
        op(1, 0, 8'h77, 0, 1);
        cmp("rstpush_ptr", 32'(pointer), 0);
        cmp("rstpush_top", 32'(top_data), 0);
`ifdef STACK_WATERMARK_EN
        op(1, 0, 8'h01, 0, 0);
        op(1, 0, 8'h02, 0, 0);
        op(1, 0, 8'h03, 0, 0);
        op(0, 1, 0, 0, 0);
        op(0, 1, 0, 0, 0);
        op(1, 0, 8'h04, 0, 0);
        cmp("wm_max", 32'(max_ptr), 3);
        cmp("wm_ptr", 32'(pointer), 2);
        op(0, 0, 0, 0, 1);
        cmp("wm_rst", 32'(max_ptr), 0);
`endif
        for (int i = 0; i < 3000; i++)
            op($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45, 8'($urandom),
               $urandom_range(0, 99) < 5, $urandom_range(0, 999) < 4);
        op(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
